// File: rtl/regfile_pkg.sv
// Shared types and writeback requester indices for the register-file writeback scheduler.
package regfile_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_REG    = 32;
    localparam int IDX_WIDTH  = $clog2(NUM_REG);

    typedef logic [IDX_WIDTH-1:0]  reg_idx_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

    // Writeback requester slots: ALU and load unit share one RF write port
    localparam int WB_ALU  = 0;
    localparam int WB_LOAD = 1;
    localparam int NUM_WB  = 2;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-requester round-robin arbiter. A lone requester is always granted; on
// contention the pointer picks, and after any grant the pointer moves to the
// other requester so neither side can starve.
module wb_rr_arbiter
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_WB-1:0] valid,
    output logic [NUM_WB-1:0] grant
);

    // ptr_q = 0 favours the ALU, 1 favours the load unit
    logic ptr_q, ptr_d;

    // Grant selection and pointer advance
    always_comb begin
        grant = valid;
        if (&valid) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
        ptr_d = ptr_q;
        if (grant[WB_ALU]) begin
            ptr_d = 1'b1;
        end else if (grant[WB_LOAD]) begin
            ptr_d = 1'b0;
        end
    end

    // Pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: arbitrates the single RF write port
// between ALU and load writebacks, keeps a busy scoreboard of registers with
// outstanding writes, and stalls decode on RAW/WAW hazards against it.
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int num_reg    = NUM_REG,
    parameter int idx_width  = $clog2(num_reg)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                issue_valid,
    input  logic                                issue_writes,
    input  logic [idx_width-1:0]                issue_rs1,
    input  logic [idx_width-1:0]                issue_rs2,
    input  logic [idx_width-1:0]                issue_rd,
    output logic                                issue_ready,
    input  logic [NUM_WB-1:0]                   wb_valid,
    input  logic [NUM_WB-1:0][idx_width-1:0]    wb_rd,
    input  logic [NUM_WB-1:0][data_width-1:0]   wb_data,
    output logic [NUM_WB-1:0]                   wb_ready,
    output logic                                rf_wen,
    output logic [idx_width-1:0]                rf_rd,
    output logic [data_width-1:0]               rf_rdv,
    output logic [num_reg-1:0]                  busy,
    output logic [idx_width:0]                  outstanding
);

    localparam int OW = idx_width + 1;

    logic [num_reg-1:0]    busy_q, busy_d, set_vec, clr_vec;
    logic [OW-1:0]         outstanding_q, outstanding_d;
    logic                  rf_wen_q, rf_wen_d;
    logic [idx_width-1:0]  rf_rd_q, rf_rd_d;
    logic [data_width-1:0] rf_rdv_q, rf_rdv_d;
    logic [NUM_WB-1:0]     grant;
    logic [idx_width-1:0]  sel_rd;
    logic [data_width-1:0] sel_data;
    logic                  issue_set;
    logic                  cnt_inc, cnt_dec;

    wb_rr_arbiter u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (wb_valid),
        .grant (grant)
    );

    assign wb_ready = grant;

    // x0 never counts as busy, so it never causes a stall
    assign issue_ready = !(busy_q[issue_rs1] && (issue_rs1 != '0)) &&
                         !(busy_q[issue_rs2] && (issue_rs2 != '0)) &&
                         !(issue_writes && (issue_rd != '0) && busy_q[issue_rd]);

    assign issue_set = issue_valid && issue_ready && issue_writes && (issue_rd != '0);

    // Per-register set (new issue) and clear (write retiring in the RF) strobes
    generate
        for (genvar gi = 0; gi < num_reg; gi++) begin : g_sb
            assign set_vec[gi] = issue_set && (issue_rd == idx_width'(gi));
            assign clr_vec[gi] = rf_wen_q  && (rf_rd_q  == idx_width'(gi));
        end
    endgenerate

    // Scoreboard next state; set overrides clear on the same index
    always_comb begin
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
        cnt_inc   = issue_set && !busy_q[issue_rd];
        cnt_dec   = rf_wen_q && busy_q[rf_rd_q] && !(issue_set && (issue_rd == rf_rd_q));
        outstanding_d = outstanding_q + OW'(cnt_inc) - OW'(cnt_dec);
    end

    // Write-stage next state; a grant to x0 is swallowed, no grant holds rd/rdv
    always_comb begin
        sel_rd   = grant[WB_LOAD] ? wb_rd[WB_LOAD]   : wb_rd[WB_ALU];
        sel_data = grant[WB_LOAD] ? wb_data[WB_LOAD] : wb_data[WB_ALU];
        rf_wen_d = (|grant) && (sel_rd != '0);
        rf_rd_d  = rf_wen_d ? sel_rd   : rf_rd_q;
        rf_rdv_d = rf_wen_d ? sel_data : rf_rdv_q;
    end

    // Scoreboard and write-stage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q        <= '0;
            outstanding_q <= '0;
            rf_wen_q      <= 1'b0;
            rf_rd_q       <= '0;
            rf_rdv_q      <= '0;
        end else begin
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
            rf_wen_q      <= rf_wen_d;
            rf_rd_q       <= rf_rd_d;
            rf_rdv_q      <= rf_rdv_d;
        end
    end

    assign rf_wen      = rf_wen_q;
    assign rf_rd       = rf_rd_q;
    assign rf_rdv      = rf_rdv_q;
    assign busy        = busy_q;
    assign outstanding = outstanding_q;

    // A writeback granted to a register with no pending write is a protocol error
    a_wb_to_busy: assert property (@(posedge clk) disable iff (rst)
        ((|grant) && (sel_rd != '0)) |-> busy_q[sel_rd]);

    // The incremental count must track the scoreboard exactly
    a_count: assert property (@(posedge clk) disable iff (rst)
        outstanding_q == OW'($countones(busy_q)));

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomised and directed bench for regfile_wb_scheduler against a
// set-based scoreboard / arbitration model.
module tb_regfile_wb_scheduler;
    import regfile_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       issue_valid, issue_writes;
    reg_idx_t                   issue_rs1, issue_rs2, issue_rd;
    logic                       issue_ready;
    logic [1:0]                 wb_valid;
    logic [1:0][IDX_WIDTH-1:0]  wb_rd;
    logic [1:0][DATA_WIDTH-1:0] wb_data;
    logic [1:0]                 wb_ready;
    logic                       rf_wen;
    reg_idx_t                   rf_rd;
    reg_data_t                  rf_rdv;
    logic [NUM_REG-1:0]         busy;
    logic [IDX_WIDTH:0]         outstanding;

    regfile_wb_scheduler dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_writes(issue_writes),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_rdv(rf_rdv),
        .busy(busy), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit verbose = 1'b1;

    // Reference model: set of registers with a pending write, who is favoured
    // on contention, and the write currently travelling to the RF.
    bit        busy_m[NUM_REG];
    int        favour_m;
    bit        pend_wen;
    int        pend_rd;
    reg_data_t pend_data;
    logic      last_ready;
    logic [1:0] last_grant;
    reg_data_t rf_m[NUM_REG];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NUM_REG-1:0] busy_vec();
        logic [NUM_REG-1:0] v = '0;
        for (int i = 0; i < NUM_REG; i++) v[i] = busy_m[i];
        return v;
    endfunction

    function automatic int busy_count();
        int n = 0;
        for (int i = 0; i < NUM_REG; i++) n += int'(busy_m[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REG; i++) busy_m[i] = 1'b0;
        favour_m  = 0;
        pend_wen  = 1'b0;
        pend_rd   = 0;
        pend_data = '0;
    endtask

    task automatic drive_idle();
        issue_valid = 0; issue_writes = 0;
        issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
        wb_valid = '0; wb_rd = '0; wb_data = '0;
    endtask

    // Starts at posedge+1: drive, check comb outputs, step the model, check registers
    task automatic cyc(input bit iv, input bit iw, input int rs1, input int rs2, input int rd,
                       input logic [1:0] wv, input int r0, input reg_data_t d0,
                       input int r1, input reg_data_t d1);
        bit exp_ready;
        logic [1:0] exp_grant;
        int g;
        issue_valid = iv; issue_writes = iw;
        issue_rs1 = IDX_WIDTH'(rs1); issue_rs2 = IDX_WIDTH'(rs2); issue_rd = IDX_WIDTH'(rd);
        wb_valid = wv;
        wb_rd[0] = IDX_WIDTH'(r0); wb_data[0] = d0;
        wb_rd[1] = IDX_WIDTH'(r1); wb_data[1] = d1;
        #2;
        exp_ready = !(rs1 != 0 && busy_m[rs1]) && !(rs2 != 0 && busy_m[rs2]) &&
                    !(iw && rd != 0 && busy_m[rd]);
        if (wv == 2'b11)      g = favour_m;
        else if (wv == 2'b01) g = 0;
        else if (wv == 2'b10) g = 1;
        else                  g = -1;
        exp_grant = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
        check_eq("issue_ready", 64'(issue_ready), 64'(exp_ready));
        check_eq("wb_ready", 64'(wb_ready), 64'(exp_grant));
        last_ready = issue_ready;
        last_grant = wb_ready;
        if (verbose)
            $display("t=%0t iv=%0b rs1=%0d rs2=%0d rd=%0d w=%0b ready=%0b | wbv=%b rd0=%0d rd1=%0d grant=%b",
                     $time, iv, rs1, rs2, rd, iw, issue_ready, wv, r0, r1, wb_ready);
        // Model edge: the retiring write clears first, a new issue sets afterwards
        if (pend_wen) begin
            busy_m[pend_rd] = 1'b0;
            rf_m[pend_rd]   = pend_data;
        end
        if (iv && exp_ready && iw && rd != 0) busy_m[rd] = 1'b1;
        pend_wen = 1'b0;
        if (g >= 0) begin
            favour_m = 1 - g;
            if (((g == 0) ? r0 : r1) != 0) begin
                pend_wen  = 1'b1;
                pend_rd   = (g == 0) ? r0 : r1;
                pend_data = (g == 0) ? d0 : d1;
            end
        end
        @(posedge clk);
        #1;
        check_eq("rf_wen", 64'(rf_wen), 64'(pend_wen));
        check_eq("rf_rd", 64'(rf_rd), 64'(pend_rd));
        check_eq("rf_rdv", 64'(rf_rdv), 64'(pend_data));
        check_eq("busy", 64'(busy), 64'(busy_vec()));
        check_eq("outstanding", 64'(outstanding), 64'(busy_count()));
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_outstanding", 64'(outstanding), 64'd0);
        check_eq("rst_rf_wen", 64'(rf_wen), 64'd0);
        check_eq("rst_rf_rd", 64'(rf_rd), 64'd0);
        check_eq("rst_rf_rdv", 64'(rf_rdv), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int q[$];
        int r0, r1;
        logic [1:0] wv;
        drive_idle();
        do_reset();

        // RAW stall on x5 resolved by an ALU writeback
        $display("test: RAW on x5");
        cyc(1, 1, 0, 0, 5, 2'b00, 0, 0, 0, 0);
        cyc(1, 0, 5, 0, 0, 2'b01, 5, 32'hDEADBEEF, 0, 0);
        check_eq("t1_stall", 64'(last_ready), 64'd0);
        check_eq("t1_wen", 64'(rf_wen), 64'd1);
        check_eq("t1_rd", 64'(rf_rd), 64'd5);
        check_eq("t1_busy5_held", 64'(busy[5]), 64'd1);
        check_eq("t1_outst", 64'(outstanding), 64'd1);
        cyc(1, 0, 5, 0, 0, 2'b00, 0, 0, 0, 0);
        check_eq("t1_still_stalled", 64'(last_ready), 64'd0);
        check_eq("t1_busy5_clear", 64'(busy[5]), 64'd0);
        cyc(1, 0, 5, 0, 0, 2'b00, 0, 0, 0, 0);
        check_eq("t1_accept", 64'(last_ready), 64'd1);

        // Contention right after reset: ALU first, then strict alternation
        $display("test: arbitration");
        do_reset();
        cyc(1, 1, 0, 0, 3, 2'b00, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 4, 2'b00, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 2'b11, 3, 32'h11, 4, 32'h22);
        check_eq("t2_first_alu", 64'(last_grant), 64'b01);
        check_eq("t2_x3", 64'(rf_rdv), 64'h11);
        cyc(0, 0, 0, 0, 0, 2'b10, 0, 0, 4, 32'h22);
        check_eq("t2_then_load", 64'(last_grant), 64'b10);
        check_eq("t2_x4_rd", 64'(rf_rd), 64'd4);
        check_eq("t2_x4", 64'(rf_rdv), 64'h22);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0);
            check_eq("t2_alternate", 64'(last_grant), (k % 2 == 0) ? 64'b01 : 64'b10);
        end

        // x0 issue and x0 writeback change nothing
        $display("test: x0");
        cyc(1, 1, 0, 0, 0, 2'b01, 0, 32'hFFFFFFFF, 0, 0);
        check_eq("t3_ready", 64'(last_ready), 64'd1);
        check_eq("t3_grant", 64'(last_grant), 64'b01);
        check_eq("t3_wen", 64'(rf_wen), 64'd0);
        check_eq("t3_busy", 64'(busy), 64'd0);

        // WAW and RAW stalls on x7
        $display("test: WAW on x7");
        cyc(1, 1, 0, 0, 7, 2'b00, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 7, 2'b00, 0, 0, 0, 0);
        check_eq("t4_waw", 64'(last_ready), 64'd0);
        cyc(1, 0, 7, 0, 0, 2'b00, 0, 0, 0, 0);
        check_eq("t4_raw", 64'(last_ready), 64'd0);
        cyc(1, 1, 0, 0, 7, 2'b01, 7, 32'h77, 0, 0);
        check_eq("t4_waw_wb", 64'(last_ready), 64'd0);
        cyc(1, 1, 0, 0, 7, 2'b00, 0, 0, 0, 0);
        check_eq("t4_waw_ws", 64'(last_ready), 64'd0);
        cyc(1, 1, 0, 0, 7, 2'b00, 0, 0, 0, 0);
        check_eq("t4_accept", 64'(last_ready), 64'd1);

        // Asynchronous reset drops an in-flight load write to x9
        $display("test: async reset");
        do_reset();
        cyc(1, 1, 0, 0, 9, 2'b00, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 2'b10, 0, 0, 9, 32'h99);
        check_eq("t5_inflight", 64'(rf_wen), 64'd1);
        drive_idle();
        #2;
        rst = 1'b1;
        #1;
        check_eq("t5_wen_drop", 64'(rf_wen), 64'd0);
        check_eq("t5_busy_drop", 64'(busy), 64'd0);
        check_eq("t5_outst_drop", 64'(outstanding), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("t5_no_write", 64'(rf_wen), 64'd0);

        // Random stream; writebacks only target registers the model says are busy
        $display("test: random stream");
        verbose = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            q.delete();
            for (int i = 1; i < NUM_REG; i++) if (busy_m[i]) q.push_back(i);
            wv = 2'($urandom_range(0, 3));
            r0 = (q.size() > 0 && $urandom_range(0, 7) != 0) ? q[$urandom_range(0, q.size() - 1)] : 0;
            r1 = (q.size() > 0 && $urandom_range(0, 7) != 0) ? q[$urandom_range(0, q.size() - 1)] : 0;
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                wv, r0, $urandom, r1, $urandom);
        end
        $display("random stream done: %0d checks so far", checks);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
